// File: rtl/machine_types.sv
// rtl/machine_types.sv - shared types for the display scan controller
package machine_types;

   typedef logic [1:0]  digit_t;
   typedef logic [15:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      RUN   = 2'd2
   } scan_state_e;

   localparam digit_t LAST_DIGIT = 2'd3;

endpackage

// File: rtl/machine_tick_gen.sv
// rtl/machine_tick_gen.sv - digit-dwell prescaler with clear, count-enable and terminal tick
module machine_tick_gen #(
   parameter int TICK_MAX = 49999,
   parameter int CNT_W    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_MAX);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == TERM);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/machine_scan_ctrl.sv
// rtl/machine_scan_ctrl.sv - digit scan FSM with anti-ghost blanking and frame-aligned word commit
module machine_scan_ctrl #(
   parameter int TICK_MAX     = 49999,
   parameter int BLANK_CYCLES = 4,
   parameter int CNT_W        = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic [1:0]  an,
   output logic [15:0] v,
   output logic        blank,
   output logic        frame_done
);

   import machine_types::*;

   localparam int BW = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [BW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;
   // With blanking disabled every digit change lands straight back in RUN.
   localparam scan_state_e TICK_STATE = (BLANK_CYCLES == 0) ? RUN : BLANK;
   localparam logic TICK_BLANK = (TICK_STATE != RUN);

   scan_state_e   state_q;
   logic [BW-1:0] blank_cnt_q;
   digit_t        an_q;
   word_t         v_q;
   word_t         pend_q;
   logic          pend_full_q;
   logic          frame_done_q;
   logic          blank_q;

   logic tick;
   logic cnt_en;
   logic accept;
   logic commit;

   assign cnt_en = enable && (state_q != IDLE);
   assign accept = in_valid && !pend_full_q;
   assign commit = tick && (an_q == LAST_DIGIT) && pend_full_q;

   machine_tick_gen #(
      .TICK_MAX (TICK_MAX),
      .CNT_W    (CNT_W)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (!cnt_en),
      .en_i   (cnt_en),
      .tick_o (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         blank_cnt_q  <= '0;
         an_q         <= '0;
         v_q          <= '0;
         pend_q       <= '0;
         pend_full_q  <= 1'b0;
         frame_done_q <= 1'b0;
         blank_q      <= 1'b1;
      end else begin
         frame_done_q <= 1'b0;

         // A full slot cannot accept, so accept and commit never coincide.
         if (accept) begin
            pend_q      <= in_data;
            pend_full_q <= 1'b1;
         end else if (commit) begin
            v_q         <= pend_q;
            pend_full_q <= 1'b0;
         end

         if (!enable) begin
            state_q <= IDLE;
            blank_q <= 1'b1;
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q     <= TICK_STATE;
                  blank_cnt_q <= BLANK_LOAD;
                  blank_q     <= TICK_BLANK;
               end
               BLANK, RUN: begin
                  if (tick) begin
                     an_q         <= an_q + 2'd1;
                     frame_done_q <= (an_q == LAST_DIGIT);
                     state_q      <= TICK_STATE;
                     blank_cnt_q  <= BLANK_LOAD;
                     blank_q      <= TICK_BLANK;
                  end else if (state_q == BLANK) begin
                     if (blank_cnt_q == '0) begin
                        state_q <= RUN;
                        blank_q <= 1'b0;
                     end else begin
                        blank_cnt_q <= blank_cnt_q - BW'(1);
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  blank_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign in_ready   = !pend_full_q;
   assign an         = an_q;
   assign v          = v_q;
   assign blank      = blank_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_machine_scan_ctrl.sv
// tb/tb_machine_scan_ctrl.sv - scoreboard bench for the display scan controller
module tb_machine_scan_ctrl;

   localparam int TM = 9;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'h0000;
   logic        in_ready;
   logic [1:0]  an;
   logic [15:0] v;
   logic        blank;
   logic        frame_done;

   int n_vec  = 0;
   int n_fail = 0;
   int j      = 0;
   logic [15:0] exp_q[$];

   machine_scan_ctrl #(
      .TICK_MAX     (TM),
      .BLANK_CYCLES (BC),
      .CNT_W        (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .an         (an),
      .v          (v),
      .blank      (blank),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t j=%0d)", name, act, exp, $time, j);
      end
   endtask

   task automatic tick_to(input int target);
      while (j < target) begin
         @(negedge clk);
         j++;
      end
   endtask

   // Each frame boundary must match the next word queued by the stimulus.
   logic [15:0] mon_exp;
   always @(negedge clk) begin
      if (!rst && frame_done) begin
         if (exp_q.size() == 0) begin
            chk("frame_done_unexpected", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("frame_v", {16'h0, v}, {16'h0, mon_exp});
            chk("frame_an", {30'h0, an}, 32'd0);
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_an", {30'h0, an}, 32'd0);
      chk("rst_v", {16'h0, v}, 32'd0);
      chk("rst_blank", {31'h0, blank}, 32'd1);
      chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
      chk("rst_frame_done", {31'h0, frame_done}, 32'd0);

      // free-running scan, no input
      @(negedge clk);
      rst = 1'b0;
      enable = 1'b1;
      j = 0;
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0000);
      for (int k = 1; k <= 80; k++) begin
         tick_to(k);
         chk("scan_an", {30'h0, an}, 32'(((k - 1) / 10) % 4));
         chk("scan_blank", {31'h0, blank}, 32'(((k - 1) % 10) < BC));
         chk("scan_frame_done", {31'h0, frame_done}, 32'((k > 1) && ((k - 1) % 40 == 0)));
      end
      chk("scan_v", {16'h0, v}, 32'h0);

      // 0xBEEF offered mid-digit 1
      tick_to(95);
      chk("beef_ready_before", {31'h0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data = 16'hBEEF;
      exp_q.push_back(16'hBEEF);
      tick_to(96);
      chk("beef_ready_after", {31'h0, in_ready}, 32'd0);
      in_valid = 1'b0;
      tick_to(120);
      chk("beef_v_pre", {16'h0, v}, 32'h0);
      chk("beef_ready_pre", {31'h0, in_ready}, 32'd0);
      tick_to(121);
      chk("beef_v_commit", {16'h0, v}, 32'hBEEF);
      chk("beef_ready_commit", {31'h0, in_ready}, 32'd1);

      // back-to-back words: second stalls until the commit
      tick_to(125);
      in_valid = 1'b1;
      in_data = 16'h1234;
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'h5678);
      tick_to(126);
      chk("b2b_ready_full", {31'h0, in_ready}, 32'd0);
      in_data = 16'h5678;
      tick_to(160);
      chk("b2b_stall", {31'h0, in_ready}, 32'd0);
      chk("b2b_v_old", {16'h0, v}, 32'hBEEF);
      tick_to(161);
      chk("b2b_v_first", {16'h0, v}, 32'h1234);
      chk("b2b_ready_commit", {31'h0, in_ready}, 32'd1);
      tick_to(162);
      chk("b2b_second_taken", {31'h0, in_ready}, 32'd0);
      in_valid = 1'b0;
      tick_to(200);
      chk("b2b_v_hold", {16'h0, v}, 32'h1234);
      tick_to(201);
      chk("b2b_v_second", {16'h0, v}, 32'h5678);

      // transfer exactly on the wrap tick
      tick_to(240);
      chk("wrap_an", {30'h0, an}, 32'd3);
      chk("wrap_ready", {31'h0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data = 16'hAAAA;
      exp_q.push_back(16'h5678);
      exp_q.push_back(16'hAAAA);
      tick_to(241);
      chk("wrap_v_unchanged", {16'h0, v}, 32'h5678);
      chk("wrap_ready_after", {31'h0, in_ready}, 32'd0);
      in_valid = 1'b0;
      tick_to(280);
      chk("wrap_v_hold", {16'h0, v}, 32'h5678);
      tick_to(281);
      chk("wrap_v_next", {16'h0, v}, 32'hAAAA);

      // disable during digit 2
      tick_to(304);
      chk("dis_an_before", {30'h0, an}, 32'd2);
      chk("dis_blank_before", {31'h0, blank}, 32'd0);
      enable = 1'b0;
      exp_q.push_back(16'hAAAA);
      tick_to(305);
      chk("dis_blank", {31'h0, blank}, 32'd1);
      chk("dis_an", {30'h0, an}, 32'd2);
      tick_to(308);
      chk("dis_blank_held", {31'h0, blank}, 32'd1);
      chk("dis_an_held", {30'h0, an}, 32'd2);
      enable = 1'b1;
      tick_to(309);
      chk("ren_blank1", {31'h0, blank}, 32'd1);
      tick_to(310);
      chk("ren_blank2", {31'h0, blank}, 32'd1);
      tick_to(311);
      chk("ren_unblank", {31'h0, blank}, 32'd0);
      chk("ren_an", {30'h0, an}, 32'd2);
      tick_to(318);
      chk("ren_dwell_last", {30'h0, an}, 32'd2);
      tick_to(319);
      chk("ren_next_digit", {30'h0, an}, 32'd3);
      chk("ren_next_blank", {31'h0, blank}, 32'd1);
      tick_to(329);
      chk("ren_wrap_an", {30'h0, an}, 32'd0);

      // asynchronous reset while 0xCAFE is pending
      tick_to(330);
      in_valid = 1'b1;
      in_data = 16'hCAFE;
      tick_to(331);
      chk("cafe_taken", {31'h0, in_ready}, 32'd0);
      in_valid = 1'b0;
      tick_to(342);
      chk("cafe_an_pre", {30'h0, an}, 32'd1);
      chk("cafe_v_pre", {16'h0, v}, 32'hAAAA);
      #1 rst = 1'b1;
      #1;
      chk("arst_an", {30'h0, an}, 32'd0);
      chk("arst_v", {16'h0, v}, 32'h0);
      chk("arst_blank", {31'h0, blank}, 32'd1);
      chk("arst_in_ready", {31'h0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      j = 0;
      exp_q.push_back(16'h0000);
      tick_to(41);
      chk("post_rst_v", {16'h0, v}, 32'h0);
      chk("post_rst_ready", {31'h0, in_ready}, 32'd1);
      tick_to(45);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
